// File: rtl/demux_1_8_deser.sv
// -----------------------------------------------------------------------------
// demux_1_8_deser
//
// Serial-to-parallel demultiplexer (1 bit in, 8 lanes out).
// Each accepted serial bit is steered to lane bit_idx, the first bit of a word
// landing on lane 0. When the last slot of a word is accepted, the assembled
// word is copied into a held output register with its own valid/ready
// handshake. A separate accumulation register lets the next word fill while
// the previous one waits for the consumer.
//
// Optional feature macro: DEMUX_PARITY_EN
//   When defined, each word carries a ninth serial bit (even parity), and
//   parity_err reports the XOR of all nine bits alongside dout.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset (priority over everything)
//   clr        in   synchronous discard of the partial word
//   din        in   serial data bit
//   din_valid  in   din is valid this cycle
//   din_ready  out  din is accepted this cycle (combinational on dout_ready)
//   bit_idx    out  lane the next accepted data bit is written to
//   dout       out  assembled word, dout[k] = k-th accepted bit
//   dout_valid out  dout holds an unconsumed word
//   parity_err out  parity check result, qualifies dout (DEMUX_PARITY_EN only)
//   dout_ready in   consumer accepts dout this cycle
// -----------------------------------------------------------------------------
module demux_1_8_deser (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [2:0] bit_idx,
    output logic [7:0] dout,
    output logic       dout_valid,
`ifdef DEMUX_PARITY_EN
    output logic       parity_err,
`endif
    input  logic       dout_ready
);

    // FILL: more slots of the current word remain after this one.
    // LAST: the next accepted bit completes the word (lane 7, or the parity
    //       slot when parity is enabled).
    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_LAST = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] acc_wr;
    logic [7:0] dout_q, dout_d;
    logic       dout_valid_q, dout_valid_d;
`ifdef DEMUX_PARITY_EN
    logic       parity_err_q, parity_err_d;
`endif

    logic       last_slot;
    logic       accept;
    logic       complete;

    // Only the completing slot can stall; lanes 0..6 always have room.
    assign last_slot = (state_q == ST_LAST);
    assign din_ready = !(last_slot && dout_valid_q && !dout_ready);
    assign accept    = din_valid && din_ready && !clr;
    assign complete  = accept && last_slot;

    always_comb begin
        state_d      = state_q;
        bit_idx_d    = bit_idx_q;
        acc_d        = acc_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
`ifdef DEMUX_PARITY_EN
        parity_err_d = parity_err_q;
`endif

        // Accumulator with the incoming bit merged in at the current lane.
        acc_wr            = acc_q;
        acc_wr[bit_idx_q] = din;

        // Consumption first; a completion in the same cycle overrides it.
        if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end

        if (clr) begin
            state_d   = ST_FILL;
            bit_idx_d = 3'd0;
            acc_d     = 8'h00;
        end else if (accept) begin
`ifdef DEMUX_PARITY_EN
            if (complete) begin
                // Parity slot: bit_idx already wrapped to 0 after lane 7.
                dout_d       = acc_q;
                parity_err_d = (^acc_q) ^ din;
                dout_valid_d = 1'b1;
                state_d      = ST_FILL;
            end else begin
                acc_d     = acc_wr;
                bit_idx_d = bit_idx_q + 3'd1;
                if (bit_idx_q == 3'd7) begin
                    state_d = ST_LAST;
                end
            end
`else
            acc_d = acc_wr;
            if (complete) begin
                dout_d       = acc_wr;
                dout_valid_d = 1'b1;
                bit_idx_d    = 3'd0;
                state_d      = ST_FILL;
            end else begin
                bit_idx_d = bit_idx_q + 3'd1;
                if (bit_idx_q == 3'd6) begin
                    state_d = ST_LAST;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FILL;
            bit_idx_q    <= 3'd0;
            dout_q       <= 8'h00;
            dout_valid_q <= 1'b0;
`ifdef DEMUX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            bit_idx_q    <= bit_idx_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
`ifdef DEMUX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Partial-word data needs no reset: every lane is rewritten before a
    // word can complete, and bit_idx/state restart on reset.
    always_ff @(posedge clk) begin
        acc_q <= acc_d;
    end

    assign bit_idx    = bit_idx_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
`ifdef DEMUX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_demux_1_8_deser.sv
module tb_demux_1_8_deser;

`ifdef DEMUX_PARITY_EN
    localparam int WB = 9;
`else
    localparam int WB = 8;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       din_ready;
    logic [2:0] bit_idx;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready = 1'b0;
`ifdef DEMUX_PARITY_EN
    logic       parity_err;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: accepted bits of the current word in arrival order,
    // plus the word last delivered to the output register.
    logic       part[$];
    logic [7:0] m_dout  = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_perr  = 1'b0;

    demux_1_8_deser dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .bit_idx    (bit_idx),
        .dout       (dout),
        .dout_valid (dout_valid),
`ifdef DEMUX_PARITY_EN
        .parity_err (parity_err),
`endif
        .dout_ready (dout_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Serial bit k of a word: data bits first, then (if enabled) even parity,
    // optionally inverted to provoke a parity error.
    function automatic logic wbit(input logic [7:0] w, input int k, input logic flip);
        if (k < 8) return w[k];
        return (^w) ^ flip;
    endfunction

    // One clock cycle: drive inputs, check handshake, advance model, check outputs.
    task automatic step(input logic v, input logic d, input logic r, input logic c, input logic rs);
        logic exp_ready;
        logic acc;
        logic done;
        logic [7:0] w;
        @(negedge clk);
        din_valid  = v;
        din        = d;
        dout_ready = r;
        clr        = c;
        rst        = rs;
        #1;
        exp_ready = !((part.size() == WB - 1) && m_valid && !r);
        if (!rs) check("din_ready", {7'd0, din_ready}, {7'd0, exp_ready});
        @(posedge clk);
        done = 1'b0;
        if (rs) begin
            part.delete();
            m_valid = 1'b0;
            m_dout  = 8'h00;
            m_perr  = 1'b0;
        end else begin
            acc = v && exp_ready && !c;
            if (c) begin
                part.delete();
            end else if (acc) begin
                part.push_back(d);
                if (part.size() == WB) begin
                    w = 8'h00;
                    for (int k = 0; k < 8; k++) w[k] = part[k];
                    m_dout = w;
                    m_perr = (WB == 9) ? ((^w) ^ part[WB-1]) : 1'b0;
                    done   = 1'b1;
                    part.delete();
                end
            end
            if (done) m_valid = 1'b1;
            else if (m_valid && r) m_valid = 1'b0;
        end
        #1;
        check("dout", dout, m_dout);
        check("dout_valid", {7'd0, dout_valid}, {7'd0, m_valid});
        check("bit_idx", {5'd0, bit_idx}, 8'(part.size() % 8));
`ifdef DEMUX_PARITY_EN
        check("parity_err", {7'd0, parity_err}, {7'd0, m_perr});
`endif
    endtask

    initial begin
        // Reset and idle
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        check("reset_dout", dout, 8'h00);
        check("reset_valid", {7'd0, dout_valid}, 8'h00);
        check("reset_idx", {5'd0, bit_idx}, 8'h00);
        check("reset_ready", {7'd0, din_ready}, 8'h01);

        // Continuous stream of 0x4D with consumer always ready
        for (int k = 0; k < WB; k++) step(1, wbit(8'h4D, k, 0), 1, 0, 0);
        check("stream_dout", dout, 8'h4D);
        check("stream_valid", {7'd0, dout_valid}, 8'h01);
        step(0, 0, 1, 0, 0);
        check("stream_valid_drop", {7'd0, dout_valid}, 8'h00);

        // Backpressure: 0xA5 held, 0x3C fills behind it and stalls on its last slot
        for (int k = 0; k < WB; k++) step(1, wbit(8'hA5, k, 0), 0, 0, 0);
        for (int k = 0; k < WB - 1; k++) step(1, wbit(8'h3C, k, 0), 0, 0, 0);
        step(1, wbit(8'h3C, WB - 1, 0), 0, 0, 0);
        step(1, wbit(8'h3C, WB - 1, 0), 0, 0, 0);
        check("bp_hold", dout, 8'hA5);
        check("bp_stall_ready", {7'd0, din_ready}, 8'h00);
        step(1, wbit(8'h3C, WB - 1, 0), 1, 0, 0);
        check("bp_release", dout, 8'h3C);
        step(0, 0, 1, 0, 0);

        // clr after 5 bits, then a fresh 0xFF
        for (int k = 0; k < 5; k++) step(1, 1'b0, 1, 0, 0);
        step(1, 1'b1, 1, 1, 0);
        check("clr_idx", {5'd0, bit_idx}, 8'h00);
        for (int k = 0; k < WB; k++) step(1, wbit(8'hFF, k, 0), 1, 0, 0);
        check("clr_word", dout, 8'hFF);
        step(0, 0, 1, 0, 0);

        // Reset mid-word with a held output word
        for (int k = 0; k < WB; k++) step(1, wbit(8'h96, k, 0), 0, 0, 0);
        for (int k = 0; k < 4; k++) step(1, 1'b1, 0, 0, 0);
        check("rst_pre_idx", {5'd0, bit_idx}, 8'h04);
        step(1, 1'b1, 0, 0, 1);
        check("rst_dout", dout, 8'h00);
        check("rst_valid", {7'd0, dout_valid}, 8'h00);
        check("rst_idx", {5'd0, bit_idx}, 8'h00);

`ifdef DEMUX_PARITY_EN
        // Parity: good and bad parity words are both delivered
        for (int k = 0; k < WB; k++) step(1, wbit(8'h4D, k, 0), 1, 0, 0);
        check("par_good_dout", dout, 8'h4D);
        check("par_good_err", {7'd0, parity_err}, 8'h00);
        for (int k = 0; k < WB; k++) step(1, wbit(8'h4D, k, 1), 1, 0, 0);
        check("par_bad_dout", dout, 8'h4D);
        check("par_bad_valid", {7'd0, dout_valid}, 8'h01);
        check("par_bad_err", {7'd0, parity_err}, 8'h01);
        step(0, 0, 1, 0, 0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0,
                 $urandom_range(0, 300) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
